// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 encodings, memory sequencer states and defaults
package chip8_pkg;

  localparam int ADDR_WIDTH_DEF  = 12;
  localparam int ACK_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ST_RD,
    ST_WR,
    DONE
  } state_t;

endpackage

// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - command, memory-port and register-file signals of the memory sequencer
interface mem_sequencer_if #(
  parameter int ADDR_WIDTH = chip8_pkg::ADDR_WIDTH_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_count;
  logic                  done;
  logic                  err;
  logic [15:0]           opcode;

  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [7:0]            mem_read_data;
  logic                  mem_read_ack;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [7:0]            mem_write_data;

  logic [3:0]            reg_addr;
  logic [7:0]            reg_rdata;
  logic                  reg_we;
  logic [7:0]            reg_wdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_count,
    input  mem_read_data, mem_read_ack, reg_rdata,
    output cmd_ready, done, err, opcode,
    output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
    output reg_addr, reg_we, reg_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_count,
    output mem_read_data, mem_read_ack, reg_rdata,
    input  cmd_ready, done, err, opcode,
    input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
    input  reg_addr, reg_we, reg_wdata
  );

endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - CHIP-8 memory port initiator: opcode fetch, FX65 load, FX55 store
module mem_sequencer
  import chip8_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_sequencer_if.master bus
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t                state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [3:0]            idx_q;
  logic [3:0]            last_q;
  logic [TW-1:0]         timer_q;
  logic [7:0]            hi_q;

  logic                  cmd_ready_q;
  logic                  done_q;
  logic                  err_q;
  logic [15:0]           opcode_q;
  logic                  mem_read_q;
  logic [ADDR_WIDTH-1:0] mem_read_addr_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_write_addr_q;
  logic [7:0]            mem_write_data_q;
  logic [3:0]            reg_addr_q;
  logic                  reg_we_q;
  logic [7:0]            reg_wdata_q;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  op_t                   cmd_op_t;

  // Address arithmetic wraps naturally at the address width.
  assign cur_addr = base_q + ADDR_WIDTH'(idx_q);
  assign nxt_addr = cur_addr + ADDR_WIDTH'(1);
  assign cmd_op_t = op_t'(bus.cmd_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      op_q             <= OP_FETCH;
      base_q           <= '0;
      idx_q            <= '0;
      last_q           <= '0;
      timer_q          <= '0;
      hi_q             <= '0;
      cmd_ready_q      <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      opcode_q         <= '0;
      mem_read_q       <= 1'b0;
      mem_read_addr_q  <= '0;
      mem_write_q      <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      reg_addr_q       <= '0;
      reg_we_q         <= 1'b0;
      reg_wdata_q      <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op_t;
            base_q      <= bus.cmd_addr;
            idx_q       <= '0;
            timer_q     <= '0;
            // A fetch is modelled as a two-byte load into the opcode register.
            last_q      <= (cmd_op_t == OP_FETCH) ? 4'd1 : bus.cmd_count;
            case (cmd_op_t)
              OP_FETCH, OP_LOAD: begin
                state           <= RD_REQ;
                mem_read_q      <= 1'b1;
                mem_read_addr_q <= bus.cmd_addr;
              end
              OP_STORE: begin
                state      <= ST_RD;
                reg_addr_q <= '0;
              end
              default: begin
                state  <= DONE;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end

        RD_REQ: begin
          state   <= RD_WAIT;
          timer_q <= timer_q + TW'(1);
        end

        RD_WAIT: begin
          if (bus.mem_read_ack) begin
            if (op_q == OP_FETCH) begin
              if (idx_q == 4'd0) hi_q <= bus.mem_read_data;
              else               opcode_q <= {hi_q, bus.mem_read_data};
            end else begin
              reg_we_q    <= 1'b1;
              reg_addr_q  <= idx_q;
              reg_wdata_q <= bus.mem_read_data;
            end
            if (idx_q == last_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx_q           <= idx_q + 4'd1;
              state           <= RD_REQ;
              mem_read_q      <= 1'b1;
              mem_read_addr_q <= nxt_addr;
              timer_q         <= '0;
            end
          end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        ST_RD: begin
          state            <= ST_WR;
          mem_write_q      <= 1'b1;
          mem_write_addr_q <= cur_addr;
          mem_write_data_q <= bus.reg_rdata;
        end

        ST_WR: begin
          if (idx_q == last_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            idx_q      <= idx_q + 4'd1;
            reg_addr_q <= idx_q + 4'd1;
            state      <= ST_RD;
          end
        end

        DONE: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.opcode         = opcode_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_read_addr  = mem_read_addr_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_write_addr = mem_write_addr_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.reg_addr       = reg_addr_q;
  assign bus.reg_we         = reg_we_q;
  assign bus.reg_wdata      = reg_wdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - self-checking bench for mem_sequencer
module tb_mem_sequencer;
  import chip8_pkg::*;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [3:0]  count;
    int          done_cyc;
    logic        err;
    logic [15:0] opcode;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_sequencer_if #(.ADDR_WIDTH(12)) bus ();

  mem_sequencer #(.ADDR_WIDTH(12), .ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem  [0:4095];
  logic [7:0] regs [0:15];
  logic       ack_q = 1'b0;
  logic [7:0] rdata_q = 8'h00;
  logic       ack_block = 1'b0;
  logic       stray_ack = 1'b0;

  // One-cycle-latency memory; writes and register updates are checked, not stored.
  always @(posedge clk) begin
    ack_q   <= (bus.mem_read === 1'b1) && !ack_block;
    rdata_q <= mem[bus.mem_read_addr];
  end
  assign bus.mem_read_ack  = ack_q | stray_ack;
  assign bus.mem_read_data = rdata_q;
  assign bus.reg_rdata     = regs[bus.reg_addr];

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_rd[$];
  ev_t  exp_rw[$];
  ev_t  exp_mw[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input int c, input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic push_expected(input logic [1:0] op, input logic [11:0] addr, input logic [3:0] count);
    logic [11:0] a;
    case (op)
      2'b00: begin
        a = addr + 12'd1;
        exp_rd.push_back(mk_ev(1, addr, 8'h00));
        exp_rd.push_back(mk_ev(3, a, 8'h00));
      end
      2'b01: for (int i = 0; i <= int'(count); i++) begin
        a = addr + 12'(i);
        exp_rd.push_back(mk_ev(2 * i + 1, a, 8'h00));
        exp_rw.push_back(mk_ev(2 * i + 3, 12'(i), mem[a]));
      end
      2'b10: for (int i = 0; i <= int'(count); i++) begin
        a = addr + 12'(i);
        exp_mw.push_back(mk_ev(2 * i + 2, a, regs[i]));
      end
      default: ;
    endcase
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [11:0] addr,
                         input logic [3:0] count, input int done_cyc, input logic exp_err,
                         input logic [15:0] exp_opcode, input int block_cyc);
    ev_t e;
    bit  seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_count = count;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      if (k == block_cyc) ack_block = 1'b1;
      if (bus.mem_read && bus.mem_write) check({tag, "_rd_wr_overlap"}, bus.mem_write, 0);
      if (bus.mem_read) begin
        if (exp_rd.size() == 0) check({tag, "_rd_extra"}, bus.mem_read, 0);
        else begin
          e = exp_rd.pop_front();
          check({tag, "_rd_cycle"}, k, e.cyc);
          check({tag, "_rd_addr"}, bus.mem_read_addr, e.addr);
        end
      end
      if (bus.reg_we) begin
        if (exp_rw.size() == 0) check({tag, "_rw_extra"}, bus.reg_we, 0);
        else begin
          e = exp_rw.pop_front();
          check({tag, "_rw_cycle"}, k, e.cyc);
          check({tag, "_rw_addr"}, bus.reg_addr, e.addr);
          check({tag, "_rw_data"}, bus.reg_wdata, e.data);
        end
      end
      if (bus.mem_write) begin
        if (exp_mw.size() == 0) check({tag, "_mw_extra"}, bus.mem_write, 0);
        else begin
          e = exp_mw.pop_front();
          check({tag, "_mw_cycle"}, k, e.cyc);
          check({tag, "_mw_addr"}, bus.mem_write_addr, e.addr);
          check({tag, "_mw_data"}, bus.mem_write_data, e.data);
        end
      end
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_done_cycle"}, k, done_cyc);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_opcode"}, bus.opcode, exp_opcode);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    ack_block = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after_done"}, bus.cmd_ready, 1);
    check({tag, "_rd_missing"}, exp_rd.size(), 0);
    check({tag, "_rw_missing"}, exp_rw.size(), 0);
    check({tag, "_mw_missing"}, exp_mw.size(), 0);
    exp_rd.delete(); exp_rw.delete(); exp_mw.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] av;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_count = '0;
    for (int a = 0; a < 4096; a++) begin
      av = 12'(a);
      mem[a] = av[7:0] ^ 8'h5A;
    end
    mem[12'h200] = 8'hA2; mem[12'h201] = 8'hF0;
    mem[12'h300] = 8'h11; mem[12'h301] = 8'h22; mem[12'h302] = 8'h33; mem[12'h303] = 8'h44;
    mem[12'hFFF] = 8'h12; mem[12'h000] = 8'h34;
    for (int i = 0; i < 16; i++) regs[i] = (i < 3) ? 8'(i + 1) : (8'hC0 | 8'(i));

    vecs[0] = '{2'b00, 12'h200, 4'd0,  5,  1'b0, 16'hA2F0};
    vecs[1] = '{2'b01, 12'h300, 4'd3,  9,  1'b0, 16'hA2F0};
    vecs[2] = '{2'b10, 12'hFFE, 4'd2,  7,  1'b0, 16'hA2F0};
    vecs[3] = '{2'b00, 12'hFFF, 4'd9,  5,  1'b0, 16'h1234};
    vecs[4] = '{2'b01, 12'hFFF, 4'd0,  3,  1'b0, 16'h1234};
    vecs[5] = '{2'b10, 12'h400, 4'd15, 33, 1'b0, 16'h1234};
    vecs[6] = '{2'b11, 12'h200, 4'd5,  1,  1'b1, 16'h1234};
    vecs[7] = '{2'b01, 12'hFF8, 4'd15, 33, 1'b0, 16'h1234};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_reg_we", bus.reg_we, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_rd_addr", bus.mem_read_addr, 0);
    check("rst_reg_addr", bus.reg_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ready", bus.cmd_ready, 1);

    for (int n = 0; n < 8; n++) begin
      push_expected(vecs[n].op, vecs[n].addr, vecs[n].count);
      run_cmd($sformatf("v%0d", n), vecs[n].op, vecs[n].addr, vecs[n].count,
              vecs[n].done_cyc, vecs[n].err, vecs[n].opcode, -1);
    end

    // Second ack withheld: timeout 15 cycles after the strobe in cycle 3, only V0 written.
    exp_rd.push_back(mk_ev(1, 12'h300, 8'h00));
    exp_rd.push_back(mk_ev(3, 12'h301, 8'h00));
    exp_rw.push_back(mk_ev(3, 12'h000, 8'h11));
    run_cmd("timeout", 2'b01, 12'h300, 4'd1, 18, 1'b1, 16'h1234, 2);

    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("stray_reg_we", bus.reg_we, 0);
      check("stray_done", bus.done, 0);
      check("stray_ready", bus.cmd_ready, 1);
      @(negedge clk);
    end

    // Reset during a STORE, right after the second write strobe.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_addr  = 12'h500;
    bus.cmd_count = 4'd5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
    end
    check("midrst_write_active", bus.mem_write, 1);
    check("midrst_write_addr", bus.mem_write_addr, 12'h501);
    reset = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 3) reset = 1'b0;
      check("midrst_mem_write", bus.mem_write, 0);
      check("midrst_mem_read", bus.mem_read, 0);
      check("midrst_reg_we", bus.reg_we, 0);
      check("midrst_done", bus.done, 0);
    end
    check("midrst_ready", bus.cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
